// File: rtl/cve2_pkg.sv
// rtl/cve2_pkg.sv - shared types for the fetch-side realigner
package cve2_pkg;

    // One buffered fetch word together with its bus error flag
    typedef struct packed {
        logic        err;
        logic [31:0] rdata;
    } fetch_entry_t;

    // A halfword starts a compressed instruction unless its opcode bits are 2'b11
    function automatic logic is_compressed(input logic [15:0] half);
        return half[1:0] != 2'b11;
    endfunction

endpackage

// File: rtl/cve2_fetch_fifo.sv
// rtl/cve2_fetch_fifo.sv - DEPTH-entry fetch word FIFO with head/head+1 peek
module cve2_fetch_fifo
    import cve2_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  fetch_entry_t  push_data_i,
    input  logic          pop_i,
    output fetch_entry_t  head_o,
    output fetch_entry_t  next_o,
    output logic [CW-1:0] count_o
);

    localparam int unsigned PW = $clog2(DEPTH);

    fetch_entry_t   mem_q [DEPTH];
    fetch_entry_t   mem_d [DEPTH];
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]  count_q, count_d;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign head_o  = mem_q[rd_ptr_q];
    assign next_o  = mem_q[next_ptr(rd_ptr_q)];
    assign count_o = count_q;

    // Next-state: flush wins; otherwise push and pop may both happen in one cycle
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = next_ptr(wr_ptr_q);
            end
            if (pop_i) begin
                rd_ptr_d = next_ptr(rd_ptr_q);
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage and pointers; contents cleared on reset so outputs read zero
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/cve2_instr_realigner.sv
// rtl/cve2_instr_realigner.sv - extracts and realigns 16/32-bit instructions from fetch words
module cve2_instr_realigner
    import cve2_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        fetch_valid_i,
    output logic        fetch_ready_o,
    input  logic [31:0] fetch_rdata_i,
    input  logic        fetch_err_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_instr_o,
    output logic        out_is_compressed_o,
    output logic [31:0] out_addr_o,
    output logic        out_err_o,
    output logic        out_err_plus2_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t  head, nxt, push_entry;
    logic [CW-1:0] count;
    logic          head_present, next_present;
    logic [15:0]   cur_half;
    logic          compressed, straddle, valid_raw, next_err;
    logic          push, fire, pop_word;
    logic          off_q, off_d;
    logic [31:0]   addr_q, addr_d;

    assign push_entry = '{err: fetch_err_i, rdata: fetch_rdata_i};

    cve2_fetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (branch_i),
        .push_i      (push),
        .push_data_i (push_entry),
        .pop_i       (pop_word),
        .head_o      (head),
        .next_o      (nxt),
        .count_o     (count)
    );

    // Pick the current halfword and decide whether the instruction is complete
    always_comb begin
        head_present = count != '0;
        next_present = count >= CW'(2);
        cur_half     = off_q ? head.rdata[31:16] : head.rdata[15:0];
        compressed   = is_compressed(cur_half);
        straddle     = off_q & ~compressed;
        // A faulting head word is reported without waiting for the word that follows it
        valid_raw    = head_present & (~straddle | next_present | head.err);
        next_err     = straddle & next_present & nxt.err;
    end

    assign out_valid_o         = valid_raw & ~branch_i;
    assign fetch_ready_o       = (count < CW'(DEPTH)) & ~branch_i & ~rst_i;
    assign out_instr_o         = off_q ? {nxt.rdata[15:0], head.rdata[31:16]} : head.rdata;
    assign out_is_compressed_o = compressed;
    assign out_addr_o          = addr_q;
    assign out_err_o           = head.err | next_err;
    assign out_err_plus2_o     = ~head.err & next_err;

    assign push     = fetch_valid_i & fetch_ready_o;
    assign fire     = out_valid_o & out_ready_i;
    // The head word is exhausted by any upper-half instruction or a full aligned 32-bit one
    assign pop_word = fire & (off_q | ~compressed);

    // Advance PC and half-offset on consumption; a branch restarts both
    always_comb begin
        addr_d = addr_q;
        off_d  = off_q;
        if (branch_i) begin
            addr_d = {branch_addr_i[31:1], 1'b0};
            off_d  = branch_addr_i[1];
        end else if (fire) begin
            addr_d = addr_q + (compressed ? 32'd2 : 32'd4);
            off_d  = off_q ^ compressed;
        end
    end

    // PC and half-offset registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_q <= '0;
            off_q  <= 1'b0;
        end else begin
            addr_q <= addr_d;
            off_q  <= off_d;
        end
    end

endmodule
